// File: rtl/rat_io_responder_pkg.sv
// Shared definitions for the MCU port-bus peripheral: port addresses, interrupt FSM
// states and the STATUS word layout.
package rat_io_pkg;

    localparam logic [7:0] PORT_LEDS     = 8'h40;
    localparam logic [7:0] PORT_SSEG     = 8'h81;
    localparam logic [7:0] PORT_INT_ACK  = 8'h22;
    localparam logic [7:0] PORT_SWITCHES = 8'h20;
    localparam logic [7:0] PORT_STATUS   = 8'h21;

    typedef enum logic {
        INT_IDLE,
        INT_PEND
    } int_state_t;

    function automatic logic [7:0] status_word(input logic irq, input logic missed,
                                               input logic level);
        return {5'b0, level, missed, irq};
    endfunction

endpackage

// File: rtl/rat_io_responder_if.sv
// MCU port bus: the core drives address/data/strobe and reads back in_port combinationally.
interface rat_io_bus_if;

    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic [7:0] in_port;

    modport master (
        output port_id,
        output out_port,
        output io_strb,
        input  in_port
    );

    modport slave (
        input  port_id,
        input  out_port,
        input  io_strb,
        output in_port
    );

endinterface

// File: rtl/rat_io_responder_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, stability counter and one-cycle rise pulse
// issued on the same edge the debounced level goes high.
module btn_debounce #(
    parameter int DB_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // stage boundary: synchronized level vs. accepted level
            rise    <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt_next == CNT_MAX) begin
                level <= sync_p1;
                rise  <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt_next;
            end
        end
    end

endmodule

// File: rtl/rat_io_responder.sv
// MCU port-bus endpoint: output registers, combinational read mux, and the
// button-driven interrupt request held until firmware acknowledges it.
module rat_io_responder
    import rat_io_pkg::*;
#(
    parameter int DB_CYCLES = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    rat_io_bus_if.slave   bus,
    input  logic [7:0]    switches,
    input  logic          btn_raw,
    output logic [7:0]    leds,
    output logic [7:0]    sseg_val,
    output logic          interrupt
);

    logic [7:0] sw_p0;
    logic [7:0] sw_p1;
    logic       btn_level;
    logic       btn_rise;
    logic       missed;
    logic       ack;
    int_state_t state;

    assign ack = bus.io_strb && (bus.port_id == PORT_INT_ACK);

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_raw),
        .level   (btn_level),
        .rise    (btn_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leds     <= 8'h00;
            sseg_val <= 8'h00;
            sw_p0    <= 8'h00;
            sw_p1    <= 8'h00;
        end else begin
            sw_p0 <= switches;
            sw_p1 <= sw_p0;
            if (bus.io_strb && bus.port_id == PORT_LEDS) leds     <= bus.out_port;
            if (bus.io_strb && bus.port_id == PORT_SSEG) sseg_val <= bus.out_port;
        end
    end

    // An ACK always returns to IDLE; an event landing on the same edge is only recorded as missed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INT_IDLE;
            interrupt <= 1'b0;
            missed    <= 1'b0;
        end else begin
            case (state)
                INT_IDLE: begin
                    if (ack) missed <= 1'b0;
                    if (btn_rise) begin
                        state     <= INT_PEND;
                        interrupt <= 1'b1;
                    end
                end
                INT_PEND: begin
                    if (ack) begin
                        state     <= INT_IDLE;
                        interrupt <= 1'b0;
                        missed    <= btn_rise;
                    end else if (btn_rise) begin
                        missed <= 1'b1;
                    end
                end
                default: begin
                    state     <= INT_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.in_port = 8'h00;
        case (bus.port_id)
            PORT_SWITCHES: bus.in_port = sw_p1;
            PORT_STATUS:   bus.in_port = status_word(interrupt, missed, btn_level);
            default:       bus.in_port = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rat_io_responder.sv
// Directed bench for rat_io_responder: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_rat_io_responder;

    logic       clk;
    logic       reset_n;
    logic [7:0] switches;
    logic       btn_raw;
    logic [7:0] leds;
    logic [7:0] sseg_val;
    logic       interrupt;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    rat_io_bus_if bus ();

    rat_io_responder #(
        .DB_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .switches  (switches),
        .btn_raw   (btn_raw),
        .leds      (leds),
        .sseg_val  (sseg_val),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_val(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic read_port(input logic [7:0] addr, input string tag, input logic [7:0] exp);
        bus.port_id = addr;
        #1;
        expect_val(exp);
        check(tag, bus.in_port);
    endtask

    task automatic write_port(input logic [7:0] addr, input logic [7:0] data);
        bus.port_id  = addr;
        bus.out_port = data;
        bus.io_strb  = 1'b1;
        tick();
        bus.io_strb  = 1'b0;
        bus.port_id  = 8'h00;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.io_strb  = 1'b1;
        bus.port_id  = 8'h40;
        bus.out_port = 8'hFF;
        switches     = 8'h00;
        btn_raw      = 1'b0;

        // reset holds registers despite an active strobe
        ticks(3);
        expect_val(8'h00); check("reset_leds", leds);
        expect_val(8'h00); check("reset_irq", {7'b0, interrupt});
        reset_n     = 1'b1;
        bus.io_strb = 1'b0;
        read_port(8'h21, "reset_status", 8'h00);

        // writes and reads
        write_port(8'h40, 8'hA5);
        expect_val(8'hA5); check("leds_write", leds);
        write_port(8'h81, 8'h3C);
        expect_val(8'h3C); check("sseg_write", sseg_val);
        switches = 8'h5A;
        bus.port_id = 8'h20;
        tick();
        expect_val(8'h00); check("switch_sync_1", bus.in_port);
        tick();
        expect_val(8'h5A); check("switch_sync_2", bus.in_port);
        write_port(8'h99, 8'hFF);
        expect_val(8'hA5); check("unmapped_leds", leds);
        expect_val(8'h3C); check("unmapped_sseg", sseg_val);
        expect_val(8'h00); check("unmapped_irq", {7'b0, interrupt});
        read_port(8'h99, "unmapped_read", 8'h00);

        // short glitches never reach the debounced level
        for (int p = 0; p < 3; p++) begin
            btn_raw = 1'b1;
            ticks(5);
            btn_raw = 1'b0;
            ticks(10);
            expect_val(8'h00); check("glitch_irq", {7'b0, interrupt});
        end
        read_port(8'h21, "glitch_status", 8'h00);

        // clean press: interrupt on exactly the 11th edge
        btn_raw = 1'b1;
        ticks(10);
        expect_val(8'h00); check("press_edge10", {7'b0, interrupt});
        tick();
        expect_val(8'h01); check("press_edge11", {7'b0, interrupt});
        read_port(8'h21, "press_status", 8'h05);

        // acknowledge handshake
        write_port(8'h22, 8'h00);
        expect_val(8'h00); check("ack_irq", {7'b0, interrupt});
        read_port(8'h21, "ack_status", 8'h04);
        write_port(8'h22, 8'h77);
        expect_val(8'h00); check("ack2_irq", {7'b0, interrupt});
        read_port(8'h21, "ack2_status", 8'h04);

        // back to PEND, then release and re-press to miss an event
        btn_raw = 1'b0; ticks(12);
        read_port(8'h21, "release_status", 8'h00);
        btn_raw = 1'b1; ticks(11);
        expect_val(8'h01); check("pend2_irq", {7'b0, interrupt});
        btn_raw = 1'b0; ticks(12);
        btn_raw = 1'b1; ticks(11);
        expect_val(8'h01); check("missed_irq", {7'b0, interrupt});
        read_port(8'h21, "missed_status", 8'h07);
        write_port(8'h22, 8'h00);
        read_port(8'h21, "missed_ack_status", 8'h04);

        // event and ACK on the same edge
        btn_raw = 1'b0; ticks(12);
        btn_raw = 1'b1; ticks(11);
        expect_val(8'h01); check("pend3_irq", {7'b0, interrupt});
        btn_raw = 1'b0; ticks(12);
        btn_raw = 1'b1; ticks(10);
        write_port(8'h22, 8'h00);
        expect_val(8'h00); check("collide_irq", {7'b0, interrupt});
        read_port(8'h21, "collide_status", 8'h06);

        // asynchronous reset in PEND, then full latency again with button held
        btn_raw = 1'b0; ticks(12);
        btn_raw = 1'b1; ticks(11);
        expect_val(8'h01); check("pend4_irq", {7'b0, interrupt});
        #2;
        reset_n = 1'b0;
        #1;
        expect_val(8'h00); check("async_rst_irq", {7'b0, interrupt});
        read_port(8'h21, "async_rst_status", 8'h00);
        expect_val(8'h00); check("async_rst_leds", leds);
        tick();
        reset_n = 1'b1;
        ticks(10);
        expect_val(8'h00); check("post_rst_edge10", {7'b0, interrupt});
        tick();
        expect_val(8'h01); check("post_rst_edge11", {7'b0, interrupt});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rat_io_responder.md
# rat_io_responder

Peripheral-side endpoint of the MCU port bus. It responds to `OUT` strobes by latching data into addressed output registers and answers `IN` reads combinationally from the addressed input source. It also owns the MCU `interrupt` line: it debounces a raw button, raises `interrupt`, and holds it until firmware acknowledges with an `OUT` to the ack port. It sits between the MCU core and the board I/O (LEDs, seven-segment, switches, button).

## Interface
- `DB_CYCLES`, default 8, number of consecutive stable synchronized samples required to accept a button level change (≥2).
- `clk`  input  1  system clock, shared with the MCU.
- `reset_n`  input  1  asynchronous, active-low reset.
- `port_id`  input  8  port address from the MCU.
- `out_port`  input  8  write data from the MCU.
- `io_strb`  input  1  one-cycle write strobe; qualifies `port_id`/`out_port`.
- `in_port`  output  8  read data to the MCU, valid in the same cycle as `port_id`.
- `switches`  input  8  board switches, asynchronous.
- `btn_raw`  input  1  board button, asynchronous, bouncy.
- `leds`  output  8  LED register.
- `sseg_val`  output  8  seven-segment value register.
- `interrupt`  output  1  level interrupt request to the MCU.

## Operation
- Port map:
  - `0x40` LEDS (W).
  - `0x81` SSEG (W).
  - `0x22` INT_ACK (W, data ignored).
  - `0x20` SWITCHES (R).
  - `0x21` STATUS (R): bit0 `interrupt`, bit1 `missed`, bit2 debounced button, bits7:3 = 0.
- Write:
  - On a rising edge with `io_strb`=1, the register addressed by `port_id` loads `out_port`.
  - Writes to unmapped ports are ignored.
  - With `io_strb`=0, no register changes.
- Read: `in_port` is a combinational mux on `port_id`.
  - SWITCHES returns the 2-FF-synchronized switch value.
  - STATUS returns as defined above.
  - Any other port returns `0x00`.
- Button path:
  - `btn_raw` passes through a 2-FF synchronizer.
  - A counter of width `$clog2(DB_CYCLES+1)` increments while the synchronized level differs from the debounced level. It clears when the two match.
  - When the counter reaches `DB_CYCLES`, the debounced level takes the synchronized value and the counter clears.
  - A debounced 0→1 transition is a button event, one cycle wide.
- Interrupt FSM:
  - **IDLE**: `interrupt`=0. On a button event, go to PEND.
  - **PEND**: `interrupt`=1. On an INT_ACK write, go to IDLE.
  - A button event while in PEND sets sticky `missed`=1.
  - An INT_ACK write clears `missed`.
  - If an event and an ACK occur in the same cycle while in PEND: the ACK wins, the FSM goes to IDLE, `missed` is set to 1, and no new interrupt is raised.
  - An INT_ACK write while in IDLE has no effect other than clearing `missed`.

## Timing
- Reset values, applied asynchronously while `reset_n`=0:
  - `leds`=0, `sseg_val`=0, `interrupt`=0.
  - `missed`=0, debounced level=0, counter=0, synchronizers=0, FSM=IDLE.
  - `in_port` follows the mux and reads `0x00` for unmapped ports.
- Write latency: a register output reflects the new value one cycle after the strobe edge.
- Read latency: zero; `in_port` is purely combinational from `port_id` and register state.
- Button latency: a clean `btn_raw` rise reaches `interrupt`=1 after 2 synchronizer cycles + `DB_CYCLES` cycles + 1 FSM cycle.
  - With `DB_CYCLES`=8, that is 11 rising edges after `btn_raw` settles.
- Interrupt hold: `interrupt` stays high for as long as it takes to acknowledge. It drops one cycle after the INT_ACK strobe edge.
- A glitch shorter than `DB_CYCLES` synchronized cycles produces no event.
- Reset asserted mid-debounce or mid-PEND drops `interrupt` immediately. After release, the block restarts from IDLE, so no stale event or interrupt survives reset.

## Structure
- Shared package `rat_io_pkg`:
  - Port address localparams: `PORT_LEDS`, `PORT_SSEG`, `PORT_INT_ACK`, `PORT_SWITCHES`, `PORT_STATUS`.
  - FSM enum `int_state_t` {`INT_IDLE`, `INT_PEND`}.
- One sub-module, `btn_debounce`, holds the synchronizer, counter and edge detect.
  - Parameter: `DB_CYCLES`.
  - Ports: `clk`, `reset_n`, `raw`, `level`, `rise`.
- Everything else is in `rat_io_responder`.

## Test plan
- **Reset:** hold `reset_n`=0 with `io_strb`=1, `port_id`=`0x40`, `out_port`=`0xFF` → `leds`=`0x00`. After release, with `port_id`=`0x21`, `in_port`=`0x00`.
- **Write/read:** `io_strb` pulse with `port_id`=`0x40`, `out_port`=`0xA5` → next cycle `leds`=`0xA5`. Same with `0x81`/`0x3C` → `sseg_val`=`0x3C`. `switches`=`0x5A` → `port_id`=`0x20` reads `0x5A` two cycles later. Write to `0x99` → no output changes.
- **Debounce:** `btn_raw` pulses high for 5 cycles, three times → `interrupt` stays 0. `btn_raw` high steady → `interrupt`=1 exactly 11 edges later, and STATUS=`0x05`.
- **Handshake:** in PEND, issue INT_ACK strobe (`0x22`) → `interrupt`=0 the next cycle, STATUS bit0=0. A second ACK causes no change.
- **Missed event:** in PEND, release and re-press the button → `interrupt` stays 1 and STATUS=`0x07`. ACK → STATUS=`0x04` (button still held). A forced same-cycle event and ACK → IDLE with `missed`=1.
- **Async reset mid-PEND:** drop `reset_n` between clock edges → `interrupt`=0 immediately. After release with the button held → a new interrupt only after the full debounce latency.
